piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 99 +++++++++
 tb/tb_piso_serializer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: accepts an N-bit word over a valid/ready
// handshake and emits it one bit per clock, allowing gapless back-to-back words.
module piso_serializer #(
   parameter int N         = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [N-1:0] D,
   input  logic         load_valid,
   output logic         load_ready,
   output logic         sout,
   output logic         sout_valid,
   output logic         done,
   output logic         busy
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   shifted_s;
   logic           last_s;
   logic           transfer_s;

   // The last bit of a word is on the line; a new word may be taken at this edge.
   assign last_s     = (state_q == SHIFT) && (cnt_q == '0);
   assign load_ready = (state_q == IDLE) || last_s;
   assign transfer_s = load_valid && load_ready;

   assign busy       = (state_q == SHIFT);
   assign sout_valid = (state_q == SHIFT);
   assign done       = last_s;
   assign sout       = (state_q == SHIFT) &&
                       (LSB_FIRST ? shreg_q[0] : shreg_q[N-1]);

   always_comb begin
      if (LSB_FIRST) begin
         shifted_s = shreg_q >> 1;
      end else begin
         shifted_s = shreg_q << 1;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (transfer_s) begin
               state_d = SHIFT;
               shreg_d = D;
               cnt_d   = CNT_LAST;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (last_s && transfer_s) begin
               shreg_d = D;
               cnt_d   = CNT_LAST;
            end else if (last_s) begin
               state_d = IDLE;
               shreg_d = shifted_s;
            end else begin
               shreg_d = shifted_s;
               cnt_d   = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // clr wins over any load or shift, discarding a partial word.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (N=4 MSB-first, N=8 LSB-first) checked
// every cycle against a queue-of-pending-bits model, plus directed literal checks.
module tb_piso_serializer;

   localparam int NA = 4;
   localparam int NB = 8;

   logic          clk = 1'b0;
   logic          clr;
   logic [NA-1:0] d_a;
   logic [NB-1:0] d_b;
   logic          lv_a, lv_b;
   logic          rdy_a, so_a, sv_a, dn_a, bsy_a;
   logic          rdy_b, so_b, sv_b, dn_b, bsy_b;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   // Model: bits still to appear on the line, head = bit in the current cycle.
   logic qa[$];
   logic qb[$];
   logic cap_a[$];
   logic cap_b[$];
   int   done_a = 0;
   int   done_b = 0;

   piso_serializer #(.N(NA), .LSB_FIRST(1'b0)) u_a (
      .clk(clk), .clr(clr), .D(d_a), .load_valid(lv_a), .load_ready(rdy_a),
      .sout(so_a), .sout_valid(sv_a), .done(dn_a), .busy(bsy_a)
   );

   piso_serializer #(.N(NB), .LSB_FIRST(1'b1)) u_b (
      .clk(clk), .clr(clr), .D(d_b), .load_valid(lv_b), .load_ready(rdy_b),
      .sout(so_b), .sout_valid(sv_b), .done(dn_b), .busy(bsy_b)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
      end
   endtask

   task automatic cmp_int(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   // Compares DUT A's captured bit stream and done pulses against literals, then clears.
   task automatic check_a(input string nm, input logic [15:0] exp, input int len,
                          input int exp_done);
      logic [15:0] v;
      v = 16'h0000;
      foreach (cap_a[i]) v = {v[14:0], cap_a[i]};
      cmp_int({nm, "_len"}, cap_a.size(), len);
      cmp_int({nm, "_bits"}, int'(v), int'(exp));
      cmp_int({nm, "_dones"}, done_a, exp_done);
      cap_a.delete();
      done_a = 0;
   endtask

   // Reference model update at each rising edge.
   initial begin
      logic ra, rb;
      forever begin
         @(posedge clk);
         if (clr) begin
            qa.delete();
            qb.delete();
         end else begin
            ra = (qa.size() <= 1);
            rb = (qb.size() <= 1);
            if (qa.size() > 0) void'(qa.pop_front());
            if (qb.size() > 0) void'(qb.pop_front());
            if (lv_a && ra) for (int i = NA - 1; i >= 0; i--) qa.push_back(d_a[i]);
            if (lv_b && rb) for (int i = 0; i < NB; i++) qb.push_back(d_b[i]);
         end
         chk_en = 1'b1;
      end
   end

   // Per-cycle compare against the model, plus capture of emitted bits.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            cmp("a_valid", sv_a, qa.size() > 0);
            cmp("a_sout", so_a, (qa.size() > 0) ? qa[0] : 1'b0);
            cmp("a_done", dn_a, qa.size() == 1);
            cmp("a_busy", bsy_a, qa.size() > 0);
            cmp("a_ready", rdy_a, qa.size() <= 1);
            cmp("b_valid", sv_b, qb.size() > 0);
            cmp("b_sout", so_b, (qb.size() > 0) ? qb[0] : 1'b0);
            cmp("b_done", dn_b, qb.size() == 1);
            cmp("b_busy", bsy_b, qb.size() > 0);
            cmp("b_ready", rdy_b, qb.size() <= 1);
            if (sv_a === 1'b1) cap_a.push_back(so_a);
            if (sv_b === 1'b1) cap_b.push_back(so_b);
            if (dn_a === 1'b1) done_a++;
            if (dn_b === 1'b1) done_b++;
         end
      end
   end

   initial begin
      logic [15:0] vb;
      clr  = 1'b1;
      lv_a = 1'b1;
      d_a  = 4'hF;
      lv_b = 1'b1;
      d_b  = 8'hFF;

      // Reset held two edges with a load request pending.
      repeat (2) @(negedge clk);
      clr  = 1'b0;
      lv_a = 1'b0;
      lv_b = 1'b0;
      @(negedge clk);
      cmp("rst_ready", rdy_a, 1'b1);
      cmp("rst_valid", sv_a, 1'b0);
      cmp("rst_busy", bsy_a, 1'b0);
      cmp("rst_b_ready", rdy_b, 1'b1);
      repeat (3) @(negedge clk);
      check_a("rst", 16'h0000, 0, 0);
      cmp_int("rst_b_bits", cap_b.size(), 0);

      // Single word, MSB first.
      lv_a = 1'b1;
      d_a  = 4'b1011;
      @(negedge clk);
      lv_a = 1'b0;
      d_a  = 4'b0000;
      repeat (6) @(negedge clk);
      check_a("single", 16'h000B, 4, 1);

      // LSB first, N=8.
      lv_b = 1'b1;
      d_b  = 8'hA5;
      @(negedge clk);
      lv_b = 1'b0;
      d_b  = 8'h00;
      repeat (10) @(negedge clk);
      vb = 16'h0000;
      foreach (cap_b[i]) vb = {vb[14:0], cap_b[i]};
      cmp_int("lsb_len", cap_b.size(), 8);
      cmp_int("lsb_bits", int'(vb), 16'h00A5);
      cmp_int("lsb_dones", done_b, 1);
      cap_b.delete();
      done_b = 0;

      // Back-to-back: second word presented in the done cycle.
      lv_a = 1'b1;
      d_a  = 4'b1100;
      repeat (4) @(negedge clk);
      cmp("b2b_done_cycle", dn_a, 1'b1);
      d_a = 4'b0011;
      @(negedge clk);
      lv_a = 1'b0;
      repeat (6) @(negedge clk);
      check_a("b2b", 16'h00C3, 8, 2);

      // Load requests during bits 1-3 are ignored.
      lv_a = 1'b1;
      d_a  = 4'b1001;
      @(negedge clk);
      d_a = 4'b0110;
      repeat (4) @(negedge clk);
      lv_a = 1'b0;
      repeat (6) @(negedge clk);
      check_a("ignore", 16'h0096, 8, 2);

      // Reset after two bits, then a clean word.
      lv_a = 1'b1;
      d_a  = 4'b1110;
      @(negedge clk);
      lv_a = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      cmp("midrst_valid", sv_a, 1'b0);
      cmp("midrst_busy", bsy_a, 1'b0);
      lv_a = 1'b1;
      d_a  = 4'b0101;
      @(negedge clk);
      lv_a = 1'b0;
      repeat (6) @(negedge clk);
      check_a("midrst", 16'h0035, 6, 1);

      // Randomized traffic on both instances with occasional resets.
      for (int c = 0; c < 800; c++) begin
         clr  = ($urandom_range(0, 39) == 0);
         lv_a = ($urandom_range(0, 3) != 0);
         lv_b = ($urandom_range(0, 3) != 0);
         d_a  = NA'($urandom);
         d_b  = NB'($urandom);
         @(negedge clk);
      end
      clr  = 1'b0;
      lv_a = 1'b0;
      lv_b = 1'b0;
      repeat (12) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
